// File: rtl/proc_run_monitor.sv
// Run controller for the processor core: holds it in reset, releases it for a bounded
// number of cycles while capturing its data output into a trace FIFO, then halts it.
module proc_run_monitor #(
  parameter int DATA_W       = 16,
  parameter int RESET_CYCLES = 1,
  parameter int MAX_CYCLES   = 10,
  parameter int DEPTH        = 16,
  parameter int CAPTURE_MODE = 0
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic [DATA_W-1:0]          i_data_in,
  output logic                       o_core_reset,
  output logic                       o_running,
  output logic                       o_done,
  input  logic                       i_rd_en,
  output logic [DATA_W-1:0]          o_rd_data,
  output logic                       o_rd_valid,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_overflow
);

  localparam int CW   = $clog2(DEPTH + 1);
  localparam int PW   = $clog2(DEPTH);
  localparam int TMAX = (RESET_CYCLES > MAX_CYCLES) ? RESET_CYCLES : MAX_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] HOLD_LOAD = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] RUN_LOAD  = TW'(MAX_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  // IDLE: core in reset, waiting | HOLD: core in reset after start | RUN: core released, sampling | DONE: halted
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RUN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [TW-1:0]       r_timer;
  logic [TW-1:0]       w_timer_nxt;
  logic                w_clear;

  logic                r_core_reset;
  logic                r_running;
  logic                r_done;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_rd_valid;
  logic                r_overflow;
  logic [CW-1:0]       r_count;
  logic [PW-1:0]       r_wptr;
  logic [PW-1:0]       r_rptr;
  logic [DATA_W-1:0]   r_last;
  logic                r_last_vld;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_sample;
  logic                w_wr;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_clear     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_state_nxt = S_HOLD;
          w_timer_nxt = HOLD_LOAD;
          w_clear     = 1'b1;
        end
      end
      S_HOLD: begin
        if (r_timer == '0) begin
          w_state_nxt = S_RUN;
          w_timer_nxt = RUN_LOAD;
        end else begin
          w_timer_nxt = r_timer - TW'(1);
        end
      end
      S_RUN: begin
        if (r_timer == '0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_timer_nxt = r_timer - TW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_sample = (r_state == S_RUN);
  assign w_wr     = w_sample && ((CAPTURE_MODE == 0) || !r_last_vld || (i_data_in != r_last));
  assign w_full   = (r_count == FULL_CNT);
  assign w_pop    = i_rd_en && (r_count != '0) && !w_clear;
  // A pop on the same edge frees a slot, so a write into a full FIFO still lands.
  assign w_push   = w_wr && (!w_full || w_pop);
  assign w_drop   = w_wr && w_full && !w_pop;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_core_reset <= 1'b1;
      r_running    <= 1'b0;
      r_done       <= 1'b0;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
      r_overflow   <= 1'b0;
      r_count      <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_last       <= '0;
      r_last_vld   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_timer      <= w_timer_nxt;
      r_core_reset <= (w_state_nxt != S_RUN);
      r_running    <= (w_state_nxt == S_RUN);
      r_done       <= (w_state_nxt == S_DONE);
      r_rd_valid   <= w_pop;
      if (w_pop) begin
        r_rd_data <= r_mem[r_rptr];
      end
      if (w_clear) begin
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
        r_last_vld <= 1'b0;
      end else begin
        if (w_push) begin
          r_wptr <= r_wptr + PW'(1);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + PW'(1);
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + CW'(1);
        end else if (!w_push && w_pop) begin
          r_count <= r_count - CW'(1);
        end
        if (w_drop) begin
          r_overflow <= 1'b1;
        end
        if (w_sample) begin
          r_last     <= i_data_in;
          r_last_vld <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_reset) begin
      r_mem[r_wptr] <= i_data_in;
    end
  end

  assign o_core_reset = r_core_reset;
  assign o_running    = r_running;
  assign o_done       = r_done;
  assign o_rd_data    = r_rd_data;
  assign o_rd_valid   = r_rd_valid;
  assign o_count      = r_count;
  assign o_overflow   = r_overflow;

endmodule
